// File: rtl/arbiter_wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
// Optional lock feature across the bundle is enabled with ARBITER_WRR_LOCK_EN.
package arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // A zero quantum would starve the holder, so it is promoted to one.
    function automatic logic [31:0] eff_weight(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

    function automatic int mod_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/arbiter_wrr_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// iLock exists only when ARBITER_WRR_LOCK_EN is defined.
interface arbiter_wrr_if #(
    parameter int NUM_PORTS       = 4,
    parameter int NUM_PORTS_WIDTH = 2,
    parameter int WEIGHT_WIDTH    = 4
);
    logic [NUM_PORTS-1:0]              iRequest;
    logic [NUM_PORTS*WEIGHT_WIDTH-1:0] iWeight;
    logic                              iPortBusy;
`ifdef ARBITER_WRR_LOCK_EN
    logic [NUM_PORTS-1:0]              iLock;
`endif
    logic [NUM_PORTS-1:0]              oGrant;
    logic [NUM_PORTS_WIDTH-1:0]        oSelected;
    logic                              oActive;
    logic [WEIGHT_WIDTH-1:0]           oCredit;

`ifdef ARBITER_WRR_LOCK_EN
    modport master (output iRequest, iWeight, iPortBusy, iLock,
                    input  oGrant, oSelected, oActive, oCredit);
    modport slave  (input  iRequest, iWeight, iPortBusy, iLock,
                    output oGrant, oSelected, oActive, oCredit);
`else
    modport master (output iRequest, iWeight, iPortBusy,
                    input  oGrant, oSelected, oActive, oCredit);
    modport slave  (input  iRequest, iWeight, iPortBusy,
                    output oGrant, oSelected, oActive, oCredit);
`endif
endinterface

// File: rtl/arbiter_rr_find_next.sv
// Rotating priority encoder: first requester after iLast, wrapping back to iLast.
// Works for any NUM_PORTS, power of two or not.
module arbiter_rr_find_next
    import arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int NUM_PORTS_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0]       iRequest,
    input  logic [NUM_PORTS_WIDTH-1:0] iLast,
    output logic [NUM_PORTS_WIDTH-1:0] oCandidate,
    output logic                       oAny
);

    always_comb begin
        int idx;
        idx        = int'(iLast);
        oCandidate = iLast;
        oAny       = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = mod_inc(idx, NUM_PORTS);
            if (!oAny && iRequest[idx]) begin
                oCandidate = NUM_PORTS_WIDTH'(idx);
                oAny       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: each holder keeps the grant for up to its quantum.
// Define ARBITER_WRR_LOCK_EN to add per-port iLock (atomic bursts).
module arbiter_wrr
    import arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int NUM_PORTS_WIDTH = 2,
    parameter int WEIGHT_WIDTH    = 4
) (
    input logic          iClk,
    input logic          iReset_n,
    arbiter_wrr_if.slave bus
);

    logic [NUM_PORTS_WIDTH-1:0] rLast_q, rLast_d;
    logic                       rActive_q, rActive_d;
    logic [WEIGHT_WIDTH-1:0]    rCredit_q, rCredit_d;
    logic [NUM_PORTS_WIDTH-1:0] candidate;
    logic                       any_req;
    logic [WEIGHT_WIDTH-1:0]    load_weight;
    logic                       holder_req;
    logic                       holder_lock;
    arb_state_e                 state;

    arbiter_rr_find_next #(
        .NUM_PORTS      (NUM_PORTS),
        .NUM_PORTS_WIDTH(NUM_PORTS_WIDTH)
    ) u_find_next (
        .iRequest  (bus.iRequest),
        .iLast     (rLast_q),
        .oCandidate(candidate),
        .oAny      (any_req)
    );

    assign state       = rActive_q ? ARB_GRANT : ARB_IDLE;
    assign holder_req  = bus.iRequest[rLast_q];
    assign load_weight = WEIGHT_WIDTH'(eff_weight(
                             32'(bus.iWeight[int'(candidate)*WEIGHT_WIDTH +: WEIGHT_WIDTH])));
`ifdef ARBITER_WRR_LOCK_EN
    assign holder_lock = bus.iLock[rLast_q];
`else
    assign holder_lock = 1'b0;
`endif

    always_comb begin
        rLast_d   = rLast_q;
        rActive_d = rActive_q;
        rCredit_d = rCredit_q;
        if (!bus.iPortBusy) begin
            if (state == ARB_GRANT && holder_req &&
                (holder_lock || rCredit_q > WEIGHT_WIDTH'(1))) begin
                // A locked holder keeps its credit so counting resumes where it paused.
                if (!holder_lock) begin
                    rCredit_d = rCredit_q - WEIGHT_WIDTH'(1);
                end
            end else if (any_req) begin
                rLast_d   = candidate;
                rActive_d = 1'b1;
                rCredit_d = load_weight;
            end else begin
                rActive_d = 1'b0;
                rCredit_d = '0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            rLast_q   <= NUM_PORTS_WIDTH'(NUM_PORTS - 1);
            rActive_q <= 1'b0;
            rCredit_q <= '0;
        end else begin
            rLast_q   <= rLast_d;
            rActive_q <= rActive_d;
            rCredit_q <= rCredit_d;
        end
    end

    assign bus.oGrant    = rActive_q ? (NUM_PORTS'(1) << rLast_q) : '0;
    assign bus.oSelected = rLast_q;
    assign bus.oActive   = rActive_q;
    assign bus.oCredit   = rCredit_q;

endmodule
